// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter sharing one TileLink A channel among N_REQ clients.
// Multi-beat data messages and back-pressured messages lock the grant until they complete.
module tl_a_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 4,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             in_valid,
    output logic [N_REQ-1:0]             in_ready,
    input  logic [N_REQ*3-1:0]           in_opcode,
    input  logic [N_REQ*3-1:0]           in_param,
    input  logic [N_REQ*SIZE_W-1:0]      in_size,
    input  logic [N_REQ*SOURCE_W-1:0]    in_source,
    input  logic [N_REQ*ADDR_W-1:0]      in_address,
    input  logic [N_REQ*(DATA_W/8)-1:0]  in_mask,
    input  logic [N_REQ*DATA_W-1:0]      in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2:0]                   out_opcode,
    output logic [2:0]                   out_param,
    output logic [SIZE_W-1:0]            out_size,
    output logic [SOURCE_W-1:0]          out_source,
    output logic [ADDR_W-1:0]            out_address,
    output logic [DATA_W/8-1:0]          out_mask,
    output logic [DATA_W-1:0]            out_data,
    output logic [IDX_W-1:0]             out_idx,
    output logic                         busy
);

    localparam int BC_W   = (1 << SIZE_W) - 4;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_lock_idx;
    logic [BC_W-1:0]   r_beat_cnt;

    logic [IDX_W-1:0]  w_scan_sel;
    logic              w_found;
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_sel_next;
    logic              w_fire;
    logic [BC_W-1:0]   w_beats;

    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin : scan
        int cand;
        w_scan_sel = r_rr_ptr;
        w_found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(r_rr_ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!w_found && in_valid[cand]) begin
                w_scan_sel = IDX_W'(cand);
                w_found    = 1'b1;
            end
        end
    end

    assign w_sel      = (r_state == IDLE) ? w_scan_sel : r_lock_idx;
    assign w_sel_next = (w_sel == IDX_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
    assign out_valid  = ~reset & ((r_state == IDLE) ? (|in_valid) : in_valid[r_lock_idx]);
    assign w_fire     = out_valid & out_ready;
    assign out_idx    = w_sel;
    assign busy       = (r_state != IDLE);

    assign out_opcode  = in_opcode[w_sel*3 +: 3];
    assign out_param   = in_param[w_sel*3 +: 3];
    assign out_size    = in_size[w_sel*SIZE_W +: SIZE_W];
    assign out_source  = in_source[w_sel*SOURCE_W +: SOURCE_W];
    assign out_address = in_address[w_sel*ADDR_W +: ADDR_W];
    assign out_mask    = in_mask[w_sel*MASK_W +: MASK_W];
    assign out_data    = in_data[w_sel*DATA_W +: DATA_W];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign in_ready[gi] = w_fire & (w_sel == IDX_W'(gi));
        end
    endgenerate

    // Only data opcodes (0..3) span multiple beats; one beat carries 16 bytes.
    always_comb begin
        w_beats = BC_W'(1);
        if (!out_opcode[2] && (out_size > SIZE_W'(4)))
            w_beats = BC_W'(1) << (out_size - SIZE_W'(4));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire) begin
                        if (w_beats == BC_W'(1)) begin
                            r_rr_ptr <= w_sel_next;
                        end else begin
                            r_state    <= BURST;
                            r_lock_idx <= w_sel;
                            r_beat_cnt <= w_beats - BC_W'(2);
                        end
                    end else if (out_valid) begin
                        r_state    <= HOLD;
                        r_lock_idx <= w_sel;
                    end
                end
                HOLD: begin
                    if (w_fire) begin
                        if (w_beats == BC_W'(1)) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_sel_next;
                        end else begin
                            r_state    <= BURST;
                            r_beat_cnt <= w_beats - BC_W'(2);
                        end
                    end
                end
                BURST: begin
                    if (w_fire) begin
                        if (r_beat_cnt == '0) begin
                            r_state  <= IDLE;
                            r_rr_ptr <= w_sel_next;
                        end else begin
                            r_beat_cnt <= r_beat_cnt - 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Bench for tl_a_arbiter: arbitration vector table, multi-cycle corner sequences,
// and a scoreboard of expected grants checked whenever the output channel fires.
module tb_tl_a_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = 3;
    localparam int ZW = 4;
    localparam int IW = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N*3-1:0]      in_opcode;
    logic [N*3-1:0]      in_param;
    logic [N*ZW-1:0]     in_size;
    logic [N*SW-1:0]     in_source;
    logic [N*AW-1:0]     in_address;
    logic [N*(DW/8)-1:0] in_mask;
    logic [N*DW-1:0]     in_data;
    logic                out_valid;
    logic                out_ready;
    logic [2:0]          out_opcode;
    logic [2:0]          out_param;
    logic [ZW-1:0]       out_size;
    logic [SW-1:0]       out_source;
    logic [AW-1:0]       out_address;
    logic [DW/8-1:0]     out_mask;
    logic [DW-1:0]       out_data;
    logic [IW-1:0]       out_idx;
    logic                busy;

    always #5 clock = ~clock;

    tl_a_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .SIZE_W(ZW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_param(in_param), .in_size(in_size),
        .in_source(in_source), .in_address(in_address), .in_mask(in_mask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
        .out_source(out_source), .out_address(out_address), .out_mask(out_mask),
        .out_data(out_data), .out_idx(out_idx), .busy(busy)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   addr;
        logic [31:0]   data;
    } sb_t;

    typedef struct {
        logic [N-1:0]  valid;
        logic [IW-1:0] idx;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] dget(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic set_data(input int i, input logic [31:0] d);
        in_data[i*DW +: DW] = {{(DW-32){1'b0}}, d};
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] sz, input logic [31:0] d);
        in_opcode[i*3 +: 3]          = op;
        in_param[i*3 +: 3]           = 3'd0;
        in_size[i*ZW +: ZW]          = sz;
        in_source[i*SW +: SW]        = SW'(i);
        in_address[i*AW +: AW]       = addr_of(i);
        in_mask[i*(DW/8) +: (DW/8)]  = '1;
        set_data(i, d);
    endtask

    task automatic push(input int i, input logic [31:0] d);
        sb_q.push_back('{idx: IW'(i), addr: addr_of(i), data: d});
    endtask

    task automatic expect_cycle(input string name, input logic ov, input logic [IW-1:0] idx,
                                input logic [N-1:0] ir, input logic b);
        chk({name, ".out_valid"}, 32'(out_valid), 32'(ov));
        if (ov) chk({name, ".out_idx"}, 32'(out_idx), 32'(idx));
        chk({name, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({name, ".busy"}, 32'(busy), 32'(b));
        $display("[TB] %s: valid=%0b idx=%0d ready=%b busy=%0b", name, out_valid, out_idx, in_ready, busy);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every accepted beat must match the oldest expected grant.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb.unexpected_fire_idx", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb.idx", 32'(out_idx), 32'(e.idx));
                chk("sb.addr", out_address, e.addr);
                chk("sb.data", out_data[31:0], e.data);
            end
        end
    end

    initial begin
        // valid mask, expected grant; rr_ptr chains 0->1->2->0->2->1->1->1->3->0
        vecs[0] = '{4'b1111, 2'd0};
        vecs[1] = '{4'b1111, 2'd1};
        vecs[2] = '{4'b1001, 2'd3};
        vecs[3] = '{4'b0110, 2'd1};
        vecs[4] = '{4'b0011, 2'd0};
        vecs[5] = '{4'b0001, 2'd0};
        vecs[6] = '{4'b0000, 2'd0};
        vecs[7] = '{4'b0100, 2'd2};
        vecs[8] = '{4'b1000, 2'd3};

        out_ready  = 1'b0;
        in_opcode  = '0;
        in_param   = '0;
        in_size    = '0;
        in_source  = '0;
        in_address = '0;
        in_mask    = '0;
        in_data    = '0;
        for (int i = 0; i < N; i++) set_req(i, 3'd4, 4'd4, dget(i));
        in_valid = 4'hF;

        @(negedge clock);
        expect_cycle("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        in_valid = '0;
        next_cycle();
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            in_valid  = vecs[v].valid;
            out_ready = 1'b1;
            if (vecs[v].valid != 0) push(int'(vecs[v].idx), dget(int'(vecs[v].idx)));
            @(negedge clock);
            expect_cycle($sformatf("vec%0d", v), vecs[v].valid != 0, vecs[v].idx,
                         (vecs[v].valid != 0) ? N'(1 << vecs[v].idx) : N'(0), 1'b0);
            next_cycle();
        end
        in_valid = '0;

        // All four valid: strict rotation 0,1,2,3,0
        in_valid = 4'hF;
        for (int c = 0; c < 5; c++) push(c % 4, dget(c % 4));
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            expect_cycle($sformatf("rot%0d", c), 1'b1, IW'(c % 4), N'(1 << (c % 4)), 1'b0);
            next_cycle();
        end
        in_valid = '0;

        // 4-beat PutFullData from req2 locks out req0 until its last beat
        set_req(2, 3'd0, 4'd6, 32'hB0);
        for (int c = 0; c < 4; c++) push(2, 32'hB0 + 32'(c));
        push(0, dget(0));
        in_valid = 4'b0101;
        for (int c = 0; c < 5; c++) begin
            if (c > 0 && c < 4) set_data(2, 32'hB0 + 32'(c));
            if (c == 4) in_valid[2] = 1'b0;
            @(negedge clock);
            expect_cycle($sformatf("burst%0d", c), 1'b1, (c < 4) ? 2'd2 : 2'd0,
                         (c < 4) ? 4'b0100 : 4'b0001, (c >= 1 && c <= 3));
            next_cycle();
        end
        in_valid = '0;
        set_req(2, 3'd4, 4'd4, dget(2));

        // Back-pressure holds req1 even after req0 joins
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        push(1, dget(1));
        push(0, dget(0));
        for (int c = 0; c < 7; c++) begin
            if (c == 2) in_valid = 4'b0011;
            if (c == 5) out_ready = 1'b1;
            if (c == 6) in_valid = 4'b0001;
            @(negedge clock);
            if (c < 6) begin
                expect_cycle($sformatf("hold%0d", c), 1'b1, 2'd1, (c == 5) ? 4'b0010 : 4'b0000, c >= 1);
                chk("hold.addr", out_address, addr_of(1));
                chk("hold.data", out_data[31:0], dget(1));
            end else begin
                expect_cycle("hold.after", 1'b1, 2'd0, 4'b0001, 1'b0);
            end
            next_cycle();
        end
        in_valid = '0;

        // Burst requester goes idle mid-message: channel stalls, req0 waits
        set_req(3, 3'd1, 4'd5, 32'hC0);
        push(3, 32'hC0);
        push(3, 32'hC1);
        push(0, dget(0));
        in_valid = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin
                in_valid[3] = 1'b0;
                set_data(3, 32'hC1);
            end
            if (c == 4) in_valid[3] = 1'b1;
            if (c == 5) in_valid[3] = 1'b0;
            @(negedge clock);
            if (c == 0)
                expect_cycle("stall0", 1'b1, 2'd3, 4'b1000, 1'b0);
            else if (c < 4)
                expect_cycle($sformatf("stall%0d", c), 1'b0, 2'd0, 4'b0000, 1'b1);
            else if (c == 4)
                expect_cycle("stall4", 1'b1, 2'd3, 4'b1000, 1'b1);
            else
                expect_cycle("stall5", 1'b1, 2'd0, 4'b0001, 1'b0);
            next_cycle();
        end
        in_valid = '0;
        set_req(3, 3'd4, 4'd4, dget(3));

        // Reset after two beats of four abandons the burst and clears rr_ptr
        set_req(2, 3'd0, 4'd6, 32'hE0);
        push(2, 32'hE0);
        push(2, 32'hE1);
        in_valid = 4'b0100;
        @(negedge clock);
        expect_cycle("rstb0", 1'b1, 2'd2, 4'b0100, 1'b0);
        next_cycle();
        set_data(2, 32'hE1);
        @(negedge clock);
        expect_cycle("rstb1", 1'b1, 2'd2, 4'b0100, 1'b1);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        expect_cycle("rstb.in_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        reset    = 1'b0;
        in_valid = '0;
        @(negedge clock);
        expect_cycle("rstb.released", 1'b0, 2'd0, 4'b0000, 1'b0);
        next_cycle();
        set_req(2, 3'd4, 4'd4, dget(2));
        in_valid = 4'b1001;
        push(0, dget(0));
        @(negedge clock);
        expect_cycle("rstb.rr0", 1'b1, 2'd0, 4'b0001, 1'b0);
        next_cycle();
        in_valid = '0;

        // Move rr_ptr to 3, then req3 and req0 together: 3 wins, then wrap to 0
        in_valid = 4'b0100;
        push(2, dget(2));
        @(negedge clock);
        expect_cycle("wrap.setup", 1'b1, 2'd2, 4'b0100, 1'b0);
        next_cycle();
        in_valid = 4'b1001;
        push(3, dget(3));
        push(0, dget(0));
        @(negedge clock);
        expect_cycle("wrap.first", 1'b1, 2'd3, 4'b1000, 1'b0);
        next_cycle();
        in_valid = 4'b0001;
        @(negedge clock);
        expect_cycle("wrap.second", 1'b1, 2'd0, 4'b0001, 1'b0);
        next_cycle();
        in_valid = '0;

        next_cycle();
        next_cycle();
        chk("sb.leftover", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
